// File: rtl/intr_sequencer_pkg.sv
// otter_intr_pkg: shared state encoding and default counter width for the interrupt sequencer.
package otter_intr_pkg;
  localparam int INTR_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, ARMED, TAKE, HANDLER} intr_state_t;
endpackage

// File: rtl/intr_sequencer_if.sv
// intr_sequencer_if: core-side request/response signals of the interrupt sequencer.
interface intr_sequencer_if #(parameter int CNT_W = otter_intr_pkg::INTR_CNT_W);
  logic             EXT_INTR;
  logic             MIE;
  logic             EX_VALID;
  logic             STALL;
  logic             MRET_REQ;
  logic             INTR;
  logic             MRET_EXEC;
  logic             MEPC_WE;
  logic             IN_HANDLER;
  logic             PENDING;
  logic [CNT_W-1:0] INTR_COUNT;
  modport master (output EXT_INTR, MIE, EX_VALID, STALL, MRET_REQ,
                  input  INTR, MRET_EXEC, MEPC_WE, IN_HANDLER, PENDING, INTR_COUNT);
  modport slave  (input  EXT_INTR, MIE, EX_VALID, STALL, MRET_REQ,
                  output INTR, MRET_EXEC, MEPC_WE, IN_HANDLER, PENDING, INTR_COUNT);
endinterface

// File: rtl/intr_sequencer_edge_latch.sv
// intr_edge_latch: rising-edge detector and pending latch for EXT_INTR.
// INTR_SYNC_EN adds a 2-flop synchronizer ahead of the edge detector.
module intr_edge_latch (
  input  logic CLK,
  input  logic RST_N,
  input  logic EXT_INTR,
  input  logic clr,
  output logic pend
);
  logic s, prev_q, pend_q;
`ifdef INTR_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) sync_q <= '0;
    else sync_q <= {sync_q[0], EXT_INTR};
  assign s = sync_q[1];
`else
  assign s = EXT_INTR;
`endif
  // a fresh edge beats the clear so an edge arriving on entry to TAKE is not lost
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= s;
      pend_q <= (s & ~prev_q) | (pend_q & ~clr);
    end
  assign pend = pend_q;
endmodule

// File: rtl/intr_sequencer.sv
// intr_sequencer: interrupt entry/mret sequencing FSM, output decode and saturating taken-counter.
// Optional INTR_SYNC_EN synchronizes EXT_INTR inside intr_edge_latch.
module intr_sequencer
  import otter_intr_pkg::*;
#(
  parameter int CNT_W = INTR_CNT_W
) (
  input logic CLK,
  input logic RST_N,
  intr_sequencer_if.slave bus
);
  intr_state_t      state_q, state_d;
  logic             pend, take_go;
  logic [CNT_W-1:0] cnt_q;
  assign take_go = (state_q == ARMED) & bus.MIE & bus.EX_VALID & ~bus.STALL;
  intr_edge_latch u_latch (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .EXT_INTR (bus.EXT_INTR),
    .clr      (take_go),
    .pend     (pend)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state_q <= IDLE;
    else state_q <= state_d;
  // TAKE ignores MIE: once INTR is driven the redirect is committed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (pend & bus.MIE) ? ARMED : IDLE;
      ARMED:   state_d = ~bus.MIE ? IDLE : take_go ? TAKE : ARMED;
      TAKE:    state_d = bus.STALL ? TAKE : HANDLER;
      HANDLER: state_d = (bus.MRET_REQ & ~bus.STALL) ? IDLE : HANDLER;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.INTR       = state_q == TAKE;
    bus.MEPC_WE    = (state_q == TAKE) & ~bus.STALL;
    bus.MRET_EXEC  = RST_N & bus.MRET_REQ & ~bus.STALL & (state_q != TAKE);
    bus.IN_HANDLER = state_q == HANDLER;
    bus.PENDING    = pend;
    bus.INTR_COUNT = cnt_q;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) cnt_q <= '0;
    else if (state_q == TAKE && !bus.STALL && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
endmodule

// File: tb/tb_intr_sequencer.sv
// tb_intr_sequencer: directed stimulus against a behavioural model, plus literal spot checks.
module tb_intr_sequencer;
  logic clk = 1'b0, rst_n = 1'b1;
  logic ext = 1'b0, mie = 1'b0, exv = 1'b0, stall = 1'b0, mret = 1'b0;
  int checks = 0, errors = 0, intr_cyc = 0, mepc_cyc = 0;
  always #5 clk = ~clk;

  intr_sequencer_if #(.CNT_W(16)) bif ();
  intr_sequencer_if #(.CNT_W(2))  sif ();
  assign bif.EXT_INTR = ext;  assign sif.EXT_INTR = ext;
  assign bif.MIE      = mie;  assign sif.MIE      = mie;
  assign bif.EX_VALID = exv;  assign sif.EX_VALID = exv;
  assign bif.STALL    = stall; assign sif.STALL   = stall;
  assign bif.MRET_REQ = mret; assign sif.MRET_REQ = mret;

  intr_sequencer #(.CNT_W(16)) dut  (.CLK(clk), .RST_N(rst_n), .bus(bif.slave));
  intr_sequencer #(.CNT_W(2))  dut2 (.CLK(clk), .RST_N(rst_n), .bus(sif.slave));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: phases of interrupt handling as independent flags, counters as plain integers
  bit m_prev, m_pend, m_arm, m_take, m_hand;
  int m_cnt, m_cnt2;
  always @(posedge clk or negedge rst_n) begin
    bit e, go, p;
    if (!rst_n) begin
      m_prev <= 0; m_pend <= 0; m_arm <= 0; m_take <= 0; m_hand <= 0; m_cnt <= 0; m_cnt2 <= 0;
    end else begin
      e  = ext & !m_prev;
      go = m_arm & mie & exv & !stall;
      p  = m_pend;
      m_prev <= ext;
      m_pend <= e | (p & !go);
      if (m_take) begin
        if (!stall) begin
          m_take <= 0; m_hand <= 1;
          m_cnt  <= (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
          m_cnt2 <= (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
        end
      end else if (m_hand) begin
        if (mret && !stall) m_hand <= 0;
      end else if (m_arm) begin
        if (!mie) m_arm <= 0;
        else if (go) begin m_arm <= 0; m_take <= 1; end
      end else if (p && mie) m_arm <= 1;
    end
  end

  always @(negedge clk) begin
    chk("intr",    bif.INTR,       m_take);
    chk("mepc_we", bif.MEPC_WE,    m_take & !stall);
    chk("mret_ex", bif.MRET_EXEC,  rst_n & mret & !stall & !m_take);
    chk("in_hdl",  bif.IN_HANDLER, m_hand);
    chk("pending", bif.PENDING,    m_pend);
    chk("count",   bif.INTR_COUNT, m_cnt);
    chk("count2",  sif.INTR_COUNT, m_cnt2);
    chk("intr2",   sif.INTR,       m_take);
    if (bif.INTR) intr_cyc++;
    if (bif.MEPC_WE) mepc_cyc++;
  end

  task automatic take_one();
    ext = 1; @(posedge clk); #1 ext = 0;
    repeat (3) @(posedge clk);
    #1 mret = 1; @(posedge clk); #1 mret = 0;
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 0;
    #2 chk("rst_intr", bif.INTR, 0); chk("rst_cnt", bif.INTR_COUNT, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1; mie = 1; exv = 1;
    @(posedge clk); #1;
    // basic entry: INTR only in the cycle after edge 2
    intr_cyc = 0; mepc_cyc = 0;
    ext = 1; @(posedge clk); #1 ext = 0;
    @(negedge clk) chk("t1_pend", bif.PENDING, 1);
    @(posedge clk); @(negedge clk) chk("t1_intr_e1", bif.INTR, 0);
    @(posedge clk); @(negedge clk) begin chk("t1_intr_e2", bif.INTR, 1); chk("t1_mepc", bif.MEPC_WE, 1); end
    @(posedge clk); @(negedge clk) begin
      chk("t1_hdl", bif.IN_HANDLER, 1); chk("t1_cnt", bif.INTR_COUNT, 1);
      chk("t1_intr_cyc", intr_cyc, 1);  chk("t1_mepc_cyc", mepc_cyc, 1);
    end
    mret = 1; #1 chk("t1_mret", bif.MRET_EXEC, 1);
    @(posedge clk); #1 mret = 0;
    @(posedge clk); #1;
    // stall 3 cycles starting in TAKE
    intr_cyc = 0; mepc_cyc = 0;
    ext = 1; @(posedge clk); #1 ext = 0;
    @(posedge clk); @(posedge clk); #1 stall = 1;
    repeat (3) @(posedge clk); #1 stall = 0;
    @(posedge clk); @(negedge clk) begin
      chk("t2_intr_cyc", intr_cyc, 4); chk("t2_mepc_cyc", mepc_cyc, 1);
      chk("t2_cnt", bif.INTR_COUNT, 2); chk("t2_hdl", bif.IN_HANDLER, 1);
    end
    mret = 1; @(posedge clk); #1 mret = 0;
    @(posedge clk); #1;
    // edge while MIE=0, taken 2 cycles after MIE rises
    mie = 0; ext = 1; @(posedge clk); #1 ext = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) begin chk("t3_pend", bif.PENDING, 1); chk("t3_nointr", bif.INTR, 0); end
      @(posedge clk); #1;
    end
    mie = 1;
    @(posedge clk); @(negedge clk) chk("t3_intr_k", bif.INTR, 0);
    @(posedge clk); @(negedge clk) chk("t3_intr_k1", bif.INTR, 1);
    @(posedge clk); #1;
    // second edge during handler, then mret
    ext = 1; @(posedge clk); #1 ext = 0;
    @(negedge clk) begin chk("t4_pend", bif.PENDING, 1); chk("t4_hdl", bif.IN_HANDLER, 1); end
    mret = 1; #1 chk("t4_mret", bif.MRET_EXEC, 1);
    @(posedge clk); #1 mret = 0;
    @(negedge clk) begin chk("t4_idle_hdl", bif.IN_HANDLER, 0); chk("t4_idle_intr", bif.INTR, 0); end
    @(posedge clk); @(negedge clk) chk("t4_armed_intr", bif.INTR, 0);
    @(posedge clk); @(negedge clk) chk("t4_take_intr", bif.INTR, 1);
    @(posedge clk); @(negedge clk) chk("t4_cnt", bif.INTR_COUNT, 4);
    // reset in handler with a pending edge
    ext = 1; @(posedge clk); #1 ext = 0;
    @(negedge clk) chk("t5_pend_pre", bif.PENDING, 1);
    #2 rst_n = 0; mret = 1;
    #1 begin
      chk("t5_intr", bif.INTR, 0); chk("t5_hdl", bif.IN_HANDLER, 0); chk("t5_pend", bif.PENDING, 0);
      chk("t5_mret", bif.MRET_EXEC, 0); chk("t5_mepc", bif.MEPC_WE, 0); chk("t5_cnt", bif.INTR_COUNT, 0);
    end
    mret = 0;
    @(negedge clk); #2 rst_n = 1;
    @(negedge clk) begin chk("t5_post_pend", bif.PENDING, 0); chk("t5_post_hdl", bif.IN_HANDLER, 0); end
    @(posedge clk); #1;
    // saturation on the narrow counter
    for (int i = 0; i < 4; i++) take_one();
    chk("t6_cnt2_sat", sif.INTR_COUNT, 3);
    chk("t6_cnt", bif.INTR_COUNT, 4);
    repeat (2) @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
